obstacle_scheduler: RTL

//  Game-level sequencer for the obstacle datapath. Runs the IDLE/RUN/OVER game FSM and

---
 rtl/obstacle_scheduler.sv | 135 +++++++++++++
 1 files changed

// File: rtl/obstacle_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// obstacle_scheduler : game FSM, spawn arbitration and velocity ramp for movers
// Optional HIGH_SCORE_EN macro builds the best-score register.  Rev 1.0
// ----------------------------------------------------------------------------
module obstacle_scheduler #(
  parameter int NUM_SLOTS    = 3,
  parameter int VEL_INIT     = 4,
  parameter int VEL_MAX      = 15,
  parameter int RAMP_TICKS   = 100,
  parameter int GAP_MIN      = 8,
  parameter int SPAWN_THRESH = 96,
  parameter int HEIGHT_MIN   = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 start,
  input  logic                 collision,
  input  logic [7:0]           rand_byte,
  input  logic [NUM_SLOTS-1:0] slot_busy,
  output logic [NUM_SLOTS-1:0] spawn,
  output logic [7:0]           spawn_height,
  output logic [3:0]           velocity,
  output logic [1:0]           state,
  output logic [15:0]          score,
  output logic [15:0]          hi_score
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_OVER = 2'd2;

  localparam int RAMP_W = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;

  logic [1:0]           cur_state;
  logic [1:0]           nxt_state;
  logic [7:0]           gap_cnt;
  logic [RAMP_W-1:0]    ramp_cnt;
  logic [NUM_SLOTS-1:0] free_pick;
  logic                 enter_run;
  logic                 end_run;
  logic                 run_tick;
  logic                 spawn_ok;
  logic                 rand_below;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) cur_state <= ST_IDLE;
    else        cur_state <= nxt_state;
  end

  // Next-state logic; the unused encoding behaves like IDLE
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      ST_RUN:  if (collision) nxt_state = ST_OVER;
      ST_OVER: if (start)     nxt_state = ST_RUN;
      default: if (start)     nxt_state = ST_RUN;
    endcase
  end

  // Output/control decode
  always_comb begin
    enter_run  = (cur_state != ST_RUN) && start;
    end_run    = (cur_state == ST_RUN) && collision;
    run_tick   = (cur_state == ST_RUN) && !collision && tick;
    rand_below = ({1'b0, rand_byte} < 9'(SPAWN_THRESH));
    spawn_ok   = run_tick && (gap_cnt == 8'd0) && !(&slot_busy) && rand_below;
  end

  // Lowest-index free slot wins: scan downward so the last hit is the lowest
  always_comb begin
    free_pick = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!slot_busy[i]) begin
        free_pick    = '0;
        free_pick[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      spawn        <= '0;
      spawn_height <= 8'd0;
      velocity     <= 4'(VEL_INIT);
      score        <= 16'd0;
      gap_cnt      <= 8'(GAP_MIN);
      ramp_cnt     <= '0;
    end else begin
      spawn <= '0;
      if (enter_run) begin
        score    <= 16'd0;
        velocity <= 4'(VEL_INIT);
        gap_cnt  <= 8'(GAP_MIN);
        ramp_cnt <= '0;
      end else if (run_tick) begin
        if (score != 16'hFFFF) score <= score + 16'd1;
        if (ramp_cnt == RAMP_W'(RAMP_TICKS - 1)) begin
          ramp_cnt <= '0;
          if (velocity < 4'(VEL_MAX)) velocity <= velocity + 4'd1;
        end else begin
          ramp_cnt <= ramp_cnt + 1'b1;
        end
        // Gap not yet expired, or spawn attempt; a refused attempt leaves gap at 0
        if (gap_cnt != 8'd0) begin
          gap_cnt <= gap_cnt - 8'd1;
        end else if (spawn_ok) begin
          spawn        <= free_pick;
          spawn_height <= 8'(HEIGHT_MIN) + {1'b0, rand_byte[6:0]};
          gap_cnt      <= 8'(GAP_MIN) + {4'd0, rand_byte[3:0]};
        end
      end
    end
  end

`ifdef HIGH_SCORE_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      hi_score <= 16'd0;
    end else if (end_run && (score > hi_score)) begin
      hi_score <= score;
    end
  end
`else
  logic unused_end_run;
  assign unused_end_run = end_run;
  assign hi_score       = 16'd0;
`endif

  assign state = cur_state;

endmodule
`default_nettype wire
